// File: rtl/transceiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transceiver_pkg
//  Description : Shared widths, DAC midscale code and the 16-entry sine table
//                used by the bit-serial transceiver front end.
//  Contents    : DATA_W, DAC_W, LUT_DEPTH, PHASE_W, DAC_MIDSCALE, SIN_LUT
//  Revision    : 1.0 - initial release
// ============================================================================
package transceiver_pkg;

    localparam int DATA_W    = 8;
    localparam int DAC_W     = 12;
    localparam int LUT_DEPTH = 16;
    localparam int PHASE_W   = $clog2(LUT_DEPTH);
    localparam int CNT_W     = $clog2(DATA_W);

    typedef logic [DAC_W-1:0]   sample_t;
    typedef logic [PHASE_W-1:0] phase_t;

    // Offset-binary zero level of the DAC.
    localparam sample_t DAC_MIDSCALE = DAC_W'(2048);

    // One carrier period: round(2048 + 2047*sin(2*pi*k/16)), k = 0..15.
    localparam sample_t SIN_LUT [LUT_DEPTH] = '{
        12'd2048, 12'd2831, 12'd3495, 12'd3939,
        12'd4095, 12'd3939, 12'd3495, 12'd2831,
        12'd2048, 12'd1265, 12'd601,  12'd157,
        12'd1,    12'd157,  12'd601,  12'd1265
    };

    // Table lookup; kept as a function so callers never index the constant
    // directly with a wider expression.
    function automatic sample_t sin_lookup(input phase_t idx);
        return SIN_LUT[idx];
    endfunction

endpackage : transceiver_pkg
`default_nettype wire

// File: rtl/bpsk_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : bpsk_modulator
//  Description : BPSK modulator. A free-running (enable-gated) phase counter
//                walks the sine table; a 0 bit selects the sample half a
//                period away, i.e. the carrier inverted by 180 degrees.
//  Ports       : clk        - system clock, rising edge
//                arst       - synchronous active-high reset
//                en         - enable; when low phase holds, output idles
//                data       - bit to modulate, sampled on rising clk
//                signal_out - registered offset-binary DAC code
//  Revision    : 1.0 - initial release
// ============================================================================
module bpsk_modulator
    import transceiver_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             data,
    output logic [DAC_W-1:0] signal_out
);

    // Half a carrier period; adding it in PHASE_W bits drops the carry,
    // which is exactly the modulo-16 wrap we want.
    localparam phase_t c_half_turn = PHASE_W'(LUT_DEPTH / 2);

    phase_t  r_phase_q;
    sample_t r_sample_q;

    phase_t  w_phase_d;
    phase_t  w_idx;
    sample_t w_sample_d;

    always_comb begin
        w_idx      = data ? r_phase_q : (r_phase_q + c_half_turn);
        w_phase_d  = r_phase_q;
        w_sample_d = DAC_MIDSCALE;
        if (en) begin
            w_phase_d  = r_phase_q + PHASE_W'(1);
            w_sample_d = sin_lookup(w_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_phase_q  <= '0;
            r_sample_q <= DAC_MIDSCALE;
        end else begin
            r_phase_q  <= w_phase_d;
            r_sample_q <= w_sample_d;
        end
    end

    assign signal_out = r_sample_q;

endmodule : bpsk_modulator
`default_nettype wire

// File: rtl/transceiver_top.sv
`default_nettype none
// ============================================================================
//  Module      : transceiver_top
//  Description : Bit-serial transceiver front end. Deserialises the serial
//                stream into MSB-first words and, in parallel, BPSK-modulates
//                the same stream onto a sine carrier for the DAC.
//  Ports       : clk        - system clock, rising edge
//                arst       - synchronous active-high reset (name historical)
//                en         - enable; when low all state holds
//                data       - serial input bit
//                done       - one-cycle strobe, new word on q
//                q          - last completed received word
//                signal_out - modulated DAC sample, offset binary
//  Revision    : 1.0 - initial release
// ============================================================================
module transceiver_top
    import transceiver_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              data,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output logic [DAC_W-1:0]  signal_out
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Receive path: shift register plus bit counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_shift_q;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [DATA_W-1:0] r_word_q;
    logic              r_done_q;

    logic [DATA_W-1:0] w_shift_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [DATA_W-1:0] w_word_d;
    logic              w_word_end;

    always_comb begin
        w_shift_d  = r_shift_q;
        w_cnt_d    = r_cnt_q;
        w_word_end = 1'b0;
        if (en) begin
            w_shift_d  = {r_shift_q[DATA_W-2:0], data};
            // Counter wraps naturally at DATA_W, a power of two.
            w_cnt_d    = r_cnt_q + CNT_W'(1);
            w_word_end = (r_cnt_q == c_last_bit);
        end
        // The completed word includes the bit arriving on this edge.
        w_word_d = w_word_end ? w_shift_d : r_word_q;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_shift_q <= '0;
            r_cnt_q   <= '0;
            r_word_q  <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_shift_q <= w_shift_d;
            r_cnt_q   <= w_cnt_d;
            r_word_q  <= w_word_d;
            r_done_q  <= w_word_end;
        end
    end

    assign q    = r_word_q;
    assign done = r_done_q;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    bpsk_modulator u_bpsk_modulator (
        .clk        (clk),
        .arst       (arst),
        .en         (en),
        .data       (data),
        .signal_out (signal_out)
    );

endmodule : transceiver_top
`default_nettype wire

// File: tb/tb_transceiver_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transceiver_top
//  Description : Self-checking bench for transceiver_top. The driver pushes
//                one expected output record per clock edge into a queue;
//                an independent monitor pops and compares after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transceiver_top;

    logic        clk;
    logic        arst;
    logic        en;
    logic        data;
    logic        done;
    logic [7:0]  q;
    logic [11:0] signal_out;

    transceiver_top dut (
        .clk        (clk),
        .arst       (arst),
        .en         (en),
        .data       (data),
        .done       (done),
        .q          (q),
        .signal_out (signal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sample;
        logic        done;
        logic [7:0]  word;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Hand-entered carrier table.
    logic [11:0] tb_sin [16] = '{
        12'd2048, 12'd2831, 12'd3495, 12'd3939, 12'd4095, 12'd3939, 12'd3495, 12'd2831,
        12'd2048, 12'd1265, 12'd601,  12'd157,  12'd1,    12'd157,  12'd601,  12'd1265
    };

    int         m_phase = 0;
    logic [7:0] m_q     = 8'h00;

    // One clock edge of stimulus plus its expected result.
    task automatic step(input logic a, input logic e, input logic d,
                        input logic exp_done, input logic [7:0] exp_word);
        exp_t x;
        @(negedge clk);
        arst = a;
        en   = e;
        data = d;
        @(posedge clk);
        cycle++;
        if (a) begin
            x.sample = 12'd2048;
            m_phase  = 0;
            m_q      = 8'h00;
            x.done   = 1'b0;
        end else if (e) begin
            x.sample = d ? tb_sin[m_phase] : tb_sin[(m_phase + 8) % 16];
            m_phase  = (m_phase + 1) % 16;
            if (exp_done) m_q = exp_word;
            x.done   = exp_done;
        end else begin
            x.sample = 12'd2048;
            x.done   = 1'b0;
        end
        x.word = m_q;
        x.cyc  = cycle;
        sb.push_back(x);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--)
            step(1'b0, 1'b1, w[i], (i == 0), w);
    endtask

    task automatic send_bit(input logic b);
        step(1'b0, 1'b1, b, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (signal_out !== x.sample) begin
                errors++;
                $display("FAIL signal_out cyc %0d: got %0d expected %0d", x.cyc, signal_out, x.sample);
            end
            checks++;
            if (done !== x.done) begin
                errors++;
                $display("FAIL done cyc %0d: got %b expected %b", x.cyc, done, x.done);
            end
            checks++;
            if (q !== x.word) begin
                errors++;
                $display("FAIL q cyc %0d: got 0x%02h expected 0x%02h", x.cyc, q, x.word);
            end
        end
    end

    initial begin
        arst = 1'b1;
        en   = 1'b0;
        data = 1'b0;

        // Reset for two edges, then release with en low.
        do_reset(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Single byte 1,0,1,0,0,1,0,1 -> 0xA5, then done must fall.
        send_word(8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Back-to-back words.
        do_reset(1);
        send_word(8'hFF);
        send_word(8'h00);
        send_bit(1'b1);

        // Carrier with data held high across a phase wrap, then held low.
        do_reset(1);
        send_word(8'hFF);
        send_word(8'hFF);
        send_bit(1'b1);
        do_reset(1);
        send_word(8'h00);

        // Enable gap mid-word with unknown data during the gap: 0xD6.
        do_reset(1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'bx, 1'b0, 8'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hD6);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-word with en high (reset wins), then 0x3C.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        send_word(8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_transceiver_top
`default_nettype wire
